grf_hazard_ctrl: RTL

- Hazard controller for the general register file in the 5-stage MIPS pipeline.
- Keeps a scoreboard of in-flight GRF writes in the E and M stages, with destination and Tnew for each.
- Decides the D-stage stall and the D-stage operand forward selects.
- Sequences multi-cycle mult/div through a busy countdown, so the GRF write port and HI/LO are never read early.

---
 rtl/grf_hazard_ctrl_pkg.sv | 32 +++
 rtl/grf_hazard_ctrl_md_busy_counter.sv | 40 ++++
 rtl/grf_hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/grf_hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the GRF hazard controller.
//   TUSE_NONE  : tuse code meaning "operand not read".
//   fwd_sel_e  : D-stage operand source select (GRF / M / E).
//   md_kind_e  : mult vs div selector for the busy counter.
//   slot_t     : one in-flight GRF write {valid, write address, tnew}.
package hazard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_M   = 2'd1,
    FWD_E   = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_kind_e;

  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic [1:0] tnew;
  } slot_t;

  // Tnew as a producer advances one stage; never wraps below zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/grf_hazard_ctrl_md_busy_counter.sv
// md_busy_counter: multi-cycle mult/div busy countdown.
//   clk   : pipeline clock
//   reset : asynchronous active-low clear
//   load  : a mult/div is issuing this cycle
//   div   : with load, 1 = div length, 0 = mult length
//   busy  : countdown nonzero
// The counter keeps running regardless of pipeline stalls.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (md_kind_e'(div) == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/grf_hazard_ctrl.sv
// grf_hazard_ctrl: GRF hazard controller for the 5-stage MIPS pipeline.
// Tracks in-flight GRF writes in E and M, decides the D-stage stall and
// operand forward selects, and blocks HI/LO access while mult/div runs.
//   clk, reset          : clock, asynchronous active-low reset
//   d_valid             : D holds a real instruction
//   d_rs, d_rt          : source register indices
//   d_tuse_rs/_rt       : cycles until operand is consumed (3 = unused)
//   d_wa, d_tnew        : destination (0 = none) and result latency from E
//   d_md_start, d_md_div: mult/div issue and its kind
//   d_md_use            : mfhi/mflo/mthi/mtlo
//   stall               : freeze PC and F/D, bubble into E
//   fwd_rs_sel/_rt_sel  : 0 = GRF, 1 = from M, 2 = from E
//   md_busy             : mult/div countdown active
module grf_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  slot_t    e_slot;
  slot_t    m_slot;
  logic     issue;
  logic     e_rs, m_rs, e_rt, m_rt;
  logic     stall_rs, stall_rt, stall_md;
  fwd_sel_e rs_sel, rt_sel;

  assign issue = d_valid & ~stall;

  // Slot pipeline: a stall pushes a bubble into E while M still advances,
  // so a pending producer always drains and the stall cannot deadlock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_slot <= '0;
      m_slot <= '0;
    end else begin
      m_slot <= '{v: e_slot.v, wa: e_slot.wa, tnew: tnew_dec(e_slot.tnew)};
      e_slot <= '{v: issue & (d_wa != 5'd0), wa: d_wa, tnew: d_tnew};
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_cnt (
    .clk  (clk),
    .reset(reset),
    .load (issue & d_md_start),
    .div  (d_md_div),
    .busy (md_busy)
  );

  always_comb begin
    e_rs = e_slot.v & (e_slot.wa == d_rs) & (d_rs != 5'd0);
    m_rs = m_slot.v & (m_slot.wa == d_rs) & (d_rs != 5'd0);
    e_rt = e_slot.v & (e_slot.wa == d_rt) & (d_rt != 5'd0);
    m_rt = m_slot.v & (m_slot.wa == d_rt) & (d_rt != 5'd0);
  end

  // The E producer is younger than M, so an E hit masks any M hit.
  always_comb begin
    stall_rs = (d_tuse_rs != TUSE_NONE) &
               ((e_rs & (e_slot.tnew > d_tuse_rs)) |
                (~e_rs & m_rs & (m_slot.tnew > d_tuse_rs)));
    stall_rt = (d_tuse_rt != TUSE_NONE) &
               ((e_rt & (e_slot.tnew > d_tuse_rt)) |
                (~e_rt & m_rt & (m_slot.tnew > d_tuse_rt)));
    stall_md = (d_md_start | d_md_use) & md_busy;
    stall    = d_valid & (stall_rs | stall_rt | stall_md);
  end

  always_comb begin
    rs_sel = FWD_GRF;
    rt_sel = FWD_GRF;
    if (e_rs && e_slot.tnew == 2'd0) begin
      rs_sel = FWD_E;
    end else if (!e_rs && m_rs && m_slot.tnew == 2'd0) begin
      rs_sel = FWD_M;
    end
    if (e_rt && e_slot.tnew == 2'd0) begin
      rt_sel = FWD_E;
    end else if (!e_rt && m_rt && m_slot.tnew == 2'd0) begin
      rt_sel = FWD_M;
    end
  end

  assign fwd_rs_sel = rs_sel;
  assign fwd_rt_sel = rt_sel;

endmodule
